dac_iq_sequencer: RTL

DAC_IQ_SEQUENCER -- requirements
Module: dac_iq_sequencer

---
 rtl/dac_iq_sequencer_pkg.sv | 20 ++
 rtl/dac_sample_fifo.sv | 67 ++++++
 rtl/dac_iq_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dac_iq_sequencer_pkg.sv
// Shared types and defaults for the DAC I/Q interleaving sequencer.
package dac_iq_sequencer_pkg;

   localparam int DEF_DAC_DATA_WIDTH = 14;
   localparam int DEF_FIFO_DEPTH     = 4;
   localparam int DEF_SYNC_CYCLES    = 2;
   localparam int UFLOW_CNT_WIDTH    = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_SLOT1 = 2'd2,
      ST_SLOT2 = 2'd3
   } seq_state_t;

   function automatic logic [UFLOW_CNT_WIDTH-1:0] sat_inc(input logic [UFLOW_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + UFLOW_CNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Single-clock sample FIFO with registered ready and show-ahead read, so a word
// can be captured by the consumer on the same edge that pops it.
module dac_sample_fifo #(
   parameter int DATA_WIDTH = 14,
   parameter int DEPTH      = 4
) (
   input  logic                  in_clk,
   input  logic                  in_rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  out_ready,
   input  logic                  in_pop,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_empty
);
   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]     LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]         wr_ptr_reg;
   logic [AW-1:0]         rd_ptr_reg;
   logic [AW:0]           level_reg;
   logic [AW:0]           level_next;
   logic                  ready_reg;
   logic                  push;
   logic                  pop;

   assign push = in_valid & ready_reg;
   assign pop  = in_pop & (level_reg != '0);

   always_comb begin
      level_next = level_reg;
      if (push && !pop)
         level_next = level_reg + LVL_ONE;
      else if (pop && !push)
         level_next = level_reg - LVL_ONE;
   end

   // ready is computed from the post-update level so it tracks "not full" with no lag
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         ready_reg  <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         level_reg <= level_next;
         ready_reg <= (level_next != LVL_FULL);
      end
   end

   always_ff @(posedge in_clk) begin
      if (push)
         mem_reg[wr_ptr_reg] <= in_data;
   end

   assign out_ready = ready_reg;
   assign out_data  = mem_reg[rd_ptr_reg];
   assign out_empty = (level_reg == '0);

endmodule

// File: rtl/dac_iq_sequencer.sv
// Interleaves buffered I (ch1) and Q (ch2) samples onto one DAC write channel,
// with an IQRESET sync phase on start and atomic pair repeat on underflow.
module dac_iq_sequencer
   import dac_iq_sequencer_pkg::*;
#(
   parameter int INT_DAC_DATA_WIDTH = DEF_DAC_DATA_WIDTH,
   parameter int INT_FIFO_DEPTH     = DEF_FIFO_DEPTH,
   parameter int INT_SYNC_CYCLES    = DEF_SYNC_CYCLES
) (
   input  logic                          in_clk,
   input  logic                          in_rst_n,
   input  logic                          in_en,
   input  logic [INT_DAC_DATA_WIDTH-1:0] in_ch1_data,
   input  logic                          in_ch1_valid,
   output logic                          out_ch1_ready,
   input  logic [INT_DAC_DATA_WIDTH-1:0] in_ch2_data,
   input  logic                          in_ch2_valid,
   output logic                          out_ch2_ready,
   output logic [INT_DAC_DATA_WIDTH-1:0] out_data,
   output logic                          out_valid,
   input  logic                          in_ready,
   output logic                          out_iqsel,
   output logic                          out_iqreset,
   output logic                          out_busy,
   output logic                          out_underflow,
   output logic [UFLOW_CNT_WIDTH-1:0]    out_underflow_cnt,
   input  logic                          in_clr_underflow
);
   localparam int            W         = INT_DAC_DATA_WIDTH;
   localparam int            SW        = (INT_SYNC_CYCLES > 1) ? $clog2(INT_SYNC_CYCLES) : 1;
   localparam logic [SW-1:0] SYNC_LAST = SW'(INT_SYNC_CYCLES - 1);
   localparam logic [SW-1:0] SYNC_ONE  = SW'(1);

   seq_state_t                 state_reg, state_next;
   logic [SW-1:0]              sync_cnt_reg, sync_cnt_next;
   logic [W-1:0]               data_reg, data_next;
   logic [W-1:0]               pair_ch1_reg, pair_ch1_next;
   logic [W-1:0]               pair_ch2_reg, pair_ch2_next;
   logic                       uflow_reg, uflow_next;
   logic [UFLOW_CNT_WIDTH-1:0] uflow_cnt_reg, uflow_cnt_next;
   logic                       fetch;
   logic                       pop;
   logic                       uflow_evt;

   logic [W-1:0] fifo_wdata [2];
   logic [W-1:0] fifo_rdata [2];
   logic [1:0]   fifo_valid;
   logic [1:0]   fifo_ready;
   logic [1:0]   fifo_empty;

   assign fifo_wdata[0] = in_ch1_data;
   assign fifo_wdata[1] = in_ch2_data;
   assign fifo_valid    = {in_ch2_valid, in_ch1_valid};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         dac_sample_fifo #(
            .DATA_WIDTH (W),
            .DEPTH      (INT_FIFO_DEPTH)
         ) u_fifo (
            .in_clk    (in_clk),
            .in_rst_n  (in_rst_n),
            .in_data   (fifo_wdata[gi]),
            .in_valid  (fifo_valid[gi]),
            .out_ready (fifo_ready[gi]),
            .in_pop    (pop),
            .out_data  (fifo_rdata[gi]),
            .out_empty (fifo_empty[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      sync_cnt_next  = sync_cnt_reg;
      data_next      = data_reg;
      pair_ch1_next  = pair_ch1_reg;
      pair_ch2_next  = pair_ch2_reg;
      uflow_next     = uflow_reg;
      uflow_cnt_next = uflow_cnt_reg;
      fetch          = 1'b0;
      pop            = 1'b0;
      uflow_evt      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (in_en) begin
               state_next    = ST_SYNC;
               sync_cnt_next = '0;
            end
         end
         ST_SYNC: begin
            if (!in_en) begin
               state_next = ST_IDLE;
            end else if (sync_cnt_reg == SYNC_LAST) begin
               state_next = ST_SLOT1;
               fetch      = 1'b1;
            end else begin
               sync_cnt_next = sync_cnt_reg + SYNC_ONE;
            end
         end
         ST_SLOT1: begin
            if (in_ready) begin
               state_next = ST_SLOT2;
               data_next  = pair_ch2_reg;
            end
         end
         ST_SLOT2: begin
            if (in_ready) begin
               if (in_en) begin
                  state_next = ST_SLOT1;
                  fetch      = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // A pair is taken only when both channels can supply; otherwise replay the last one
      if (fetch) begin
         if (fifo_empty != 2'b00) begin
            uflow_evt = 1'b1;
            data_next = pair_ch1_reg;
         end else begin
            pop           = 1'b1;
            pair_ch1_next = fifo_rdata[0];
            pair_ch2_next = fifo_rdata[1];
            data_next     = fifo_rdata[0];
         end
      end

      if (in_clr_underflow) begin
         uflow_next     = 1'b0;
         uflow_cnt_next = '0;
      end
      if (uflow_evt) begin
         uflow_next     = 1'b1;
         uflow_cnt_next = sat_inc(uflow_cnt_next);
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_reg     <= ST_IDLE;
         sync_cnt_reg  <= '0;
         data_reg      <= '0;
         pair_ch1_reg  <= '0;
         pair_ch2_reg  <= '0;
         uflow_reg     <= 1'b0;
         uflow_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         sync_cnt_reg  <= sync_cnt_next;
         data_reg      <= data_next;
         pair_ch1_reg  <= pair_ch1_next;
         pair_ch2_reg  <= pair_ch2_next;
         uflow_reg     <= uflow_next;
         uflow_cnt_reg <= uflow_cnt_next;
      end
   end

   assign out_data          = data_reg;
   assign out_valid         = (state_reg == ST_SLOT1) || (state_reg == ST_SLOT2);
   assign out_iqsel         = (state_reg == ST_SLOT1);
   assign out_iqreset       = (state_reg == ST_IDLE) || (state_reg == ST_SYNC);
   assign out_busy          = (state_reg != ST_IDLE);
   assign out_underflow     = uflow_reg;
   assign out_underflow_cnt = uflow_cnt_reg;
   assign out_ch1_ready     = fifo_ready[0];
   assign out_ch2_ready     = fifo_ready[1];

endmodule
